// File: rtl/soc_bus_pkg.sv
// Shared types and helpers for the SoC memory bus bridge.
package soc_bus_pkg;

   localparam int unsigned ADR_W  = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned WREN_W = 4;

   localparam logic [1:0] REGION_RAM  = 2'b00;
   localparam logic [1:0] REGION_MMIO = 2'b01;
   localparam logic [1:0] REGION_ROM  = 2'b10;
   localparam logic [1:0] REGION_ERR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SRC_DBG  = 2'd0,
      SRC_DBUS = 2'd1,
      SRC_IBUS = 2'd2
   } src_t;

   // Latched command for the single in-flight transaction.
   typedef struct packed {
      src_t              src;
      logic              wr;
      logic              err;
      logic [ADR_W-1:0]  adr;
      logic [DATA_W-1:0] data;
      logic [WREN_W-1:0] wren;
   } cmd_t;

   // Two-bit region field whose MSB sits at bit 'hi' of the address.
   function automatic logic [1:0] region_of(input logic [ADR_W-1:0] adr, input int unsigned hi);
      return 2'(adr >> (hi - 1));
   endfunction

endpackage

// File: rtl/vex_bus_bridge.sv
// Registered arbiter between iBus, dBus, debug port and the shared memory bus.
// One transaction at a time: IDLE (grant) -> ACCESS (mem_op) -> RESP (capture).
module vex_bus_bridge
   import soc_bus_pkg::*;
#(
   parameter int unsigned REGION_HI  = 17,
   parameter logic [1:0]  ROM_REGION = REGION_ROM,
   parameter logic [1:0]  ERR_REGION = REGION_ERR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_run,
   input  logic        ibus_cmd_valid,
   output logic        ibus_cmd_ready,
   input  logic [31:0] ibus_cmd_pc,
   output logic        ibus_rsp_valid,
   output logic        ibus_rsp_error,
   output logic [31:0] ibus_rsp_inst,
   input  logic        dbus_cmd_valid,
   output logic        dbus_cmd_ready,
   input  logic        dbus_cmd_wr,
   input  logic [3:0]  dbus_cmd_mask,
   input  logic [31:0] dbus_cmd_address,
   input  logic [31:0] dbus_cmd_data,
   input  logic [1:0]  dbus_cmd_size,
   output logic        dbus_rsp_ready,
   output logic        dbus_rsp_error,
   output logic [31:0] dbus_rsp_data,
   input  logic        dbg_mem_op,
   input  logic        dbg_rw,
   input  logic [31:0] dbg_adr,
   input  logic [31:0] dbg_do,
   output logic [31:0] dbg_di,
   output logic        dbg_mem_rdy,
   output logic        mem_op,
   output logic [31:0] mem_adr,
   output logic [3:0]  mem_wren,
   output logic [31:0] mem_di,
   input  logic [31:0] mem_do
);

   state_t            state_q, state_d;
   cmd_t              cmd_q, cmd_d;
   logic              dbg_busy_q, dbg_busy_d, dbg_busy_set;
   logic [DATA_W-1:0] rd_data;
   logic [1:0]        dbg_region, dbus_region, ibus_region;

   logic              mem_op_d;
   logic [ADR_W-1:0]  mem_adr_d;
   logic [WREN_W-1:0] mem_wren_d;
   logic [DATA_W-1:0] mem_di_d;
   logic              ibus_rsp_valid_d, ibus_rsp_error_d;
   logic [DATA_W-1:0] ibus_rsp_inst_d;
   logic              dbus_rsp_ready_d, dbus_rsp_error_d;
   logic [DATA_W-1:0] dbus_rsp_data_d;
   logic [DATA_W-1:0] dbg_di_d;
   logic              dbg_mem_rdy_d;

   // Access size is implied by the byte mask; the size field is not needed.
   logic              unused_size;
   assign unused_size = ^dbus_cmd_size;

   assign dbg_region  = region_of(dbg_adr, REGION_HI);
   assign dbus_region = region_of(dbus_cmd_address, REGION_HI);
   assign ibus_region = region_of(ibus_cmd_pc, REGION_HI);

   // Arbitration, command latch, response generation and next memory-bus drive.
   always_comb begin
      state_d          = state_q;
      cmd_d            = cmd_q;
      ibus_cmd_ready   = 1'b0;
      dbus_cmd_ready   = 1'b0;
      ibus_rsp_valid_d = 1'b0;
      ibus_rsp_error_d = ibus_rsp_error;
      ibus_rsp_inst_d  = ibus_rsp_inst;
      dbus_rsp_ready_d = 1'b0;
      dbus_rsp_error_d = dbus_rsp_error;
      dbus_rsp_data_d  = dbus_rsp_data;
      dbg_di_d         = dbg_di;
      dbg_mem_rdy_d    = 1'b0;
      dbg_busy_set     = 1'b0;
      mem_op_d         = 1'b0;
      mem_adr_d        = '0;
      mem_wren_d       = '0;
      mem_di_d         = '0;
      rd_data          = cmd_q.err ? '0 : mem_do;

      unique case (state_q)
         IDLE: begin
            if (!reset) begin
               if (dbg_mem_op && !dbg_busy_q) begin
                  cmd_d.src  = SRC_DBG;
                  cmd_d.wr   = ~dbg_rw;
                  cmd_d.err  = (dbg_region == ERR_REGION);
                  cmd_d.adr  = dbg_adr;
                  cmd_d.data = dbg_rw ? '0 : dbg_do;
                  cmd_d.wren = {WREN_W{~dbg_rw}};
                  state_d    = ACCESS;
               end else if (cpu_run && dbus_cmd_valid) begin
                  dbus_cmd_ready = 1'b1;
                  cmd_d.src  = SRC_DBUS;
                  cmd_d.wr   = dbus_cmd_wr;
                  cmd_d.err  = (dbus_region == ERR_REGION);
                  cmd_d.adr  = dbus_cmd_address;
                  cmd_d.data = dbus_cmd_wr ? dbus_cmd_data : '0;
                  cmd_d.wren = (dbus_cmd_wr && (dbus_region != ROM_REGION)) ? dbus_cmd_mask : '0;
                  state_d    = ACCESS;
               end else if (cpu_run && ibus_cmd_valid) begin
                  ibus_cmd_ready = 1'b1;
                  cmd_d.src  = SRC_IBUS;
                  cmd_d.wr   = 1'b0;
                  cmd_d.err  = (ibus_region == ERR_REGION);
                  cmd_d.adr  = ibus_cmd_pc;
                  cmd_d.data = '0;
                  cmd_d.wren = '0;
                  state_d    = ACCESS;
               end
            end
         end
         ACCESS: state_d = RESP;
         RESP: begin
            state_d = IDLE;
            unique case (cmd_q.src)
               SRC_IBUS: begin
                  ibus_rsp_valid_d = 1'b1;
                  ibus_rsp_error_d = cmd_q.err;
                  ibus_rsp_inst_d  = rd_data;
               end
               SRC_DBUS: begin
                  if (!cmd_q.wr) begin
                     dbus_rsp_ready_d = 1'b1;
                     dbus_rsp_error_d = cmd_q.err;
                     dbus_rsp_data_d  = rd_data;
                  end
               end
               SRC_DBG: begin
                  dbg_mem_rdy_d = 1'b1;
                  dbg_busy_set  = 1'b1;
                  if (!cmd_q.wr) dbg_di_d = rd_data;
               end
               default: ;
            endcase
         end
         default: state_d = IDLE;
      endcase

      // The OR-bus is driven only during ACCESS; unmapped accesses stay silent.
      if (state_d == ACCESS) begin
         mem_op_d   = ~cmd_d.err;
         mem_adr_d  = cmd_d.adr;
         mem_di_d   = cmd_d.data;
         mem_wren_d = cmd_d.err ? '0 : cmd_d.wren;
      end

      // A held dbg_mem_op is served once; busy clears when the request drops.
      dbg_busy_d = dbg_busy_set | (dbg_busy_q & dbg_mem_op);
   end

   // State, command latch and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         cmd_q          <= '0;
         dbg_busy_q     <= 1'b0;
         mem_op         <= 1'b0;
         mem_adr        <= '0;
         mem_wren       <= '0;
         mem_di         <= '0;
         ibus_rsp_valid <= 1'b0;
         ibus_rsp_error <= 1'b0;
         ibus_rsp_inst  <= '0;
         dbus_rsp_ready <= 1'b0;
         dbus_rsp_error <= 1'b0;
         dbus_rsp_data  <= '0;
         dbg_di         <= '0;
         dbg_mem_rdy    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cmd_q          <= cmd_d;
         dbg_busy_q     <= dbg_busy_d;
         mem_op         <= mem_op_d;
         mem_adr        <= mem_adr_d;
         mem_wren       <= mem_wren_d;
         mem_di         <= mem_di_d;
         ibus_rsp_valid <= ibus_rsp_valid_d;
         ibus_rsp_error <= ibus_rsp_error_d;
         ibus_rsp_inst  <= ibus_rsp_inst_d;
         dbus_rsp_ready <= dbus_rsp_ready_d;
         dbus_rsp_error <= dbus_rsp_error_d;
         dbus_rsp_data  <= dbus_rsp_data_d;
         dbg_di         <= dbg_di_d;
         dbg_mem_rdy    <= dbg_mem_rdy_d;
      end
   end

endmodule
